// File: rtl/io_input_port.sv
// rtl/io_input_port.sv - synchronised, debounced switch/button input port with press-event interrupt
module io_input_port #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [9:0]  SW,
  input  logic [3:0]  KEY,
  input  logic        cs,
  input  logic [1:0]  addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int              N_IN      = 14;
  localparam logic [N_IN-1:0] SYNC_IDLE = {4'hF, 10'h000};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_SW_STATE  = 2'd0;
  localparam logic [1:0] ADDR_KEY_STATE = 2'd1;
  localparam logic [1:0] ADDR_KEY_EDGE  = 2'd2;
  localparam logic [1:0] ADDR_IRQ_EN    = 2'd3;

  logic [N_IN-1:0]  sync1_q, sync1_d;
  logic [N_IN-1:0]  sync2_q, sync2_d;
  logic [N_IN-1:0]  stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];
  logic [3:0]       key_edge_q, key_edge_d;
  logic [3:0]       irq_en_q, irq_en_d;

  logic [N_IN-1:0]  sync_val;
  logic             reg_wr;
  logic [3:0]       edge_set;
  logic [3:0]       edge_clr;
  logic             unused_wdata;

  assign unused_wdata = ^wdata[31:4];

  // Keys are inverted after the synchroniser so every debounced bit reads 1 = active.
  always_comb begin
    sync1_d  = {KEY, SW};
    sync2_d  = sync1_q;
    sync_val = {~sync2_q[13:10], sync2_q[9:0]};
  end

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i] = '0;
      if (sync_val[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync_val[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A new press and a W1C of the same bit in one cycle keeps the bit set.
  always_comb begin
    reg_wr     = cs & wen;
    edge_set   = stable_d[13:10] & ~stable_q[13:10];
    edge_clr   = (reg_wr && addr == ADDR_KEY_EDGE) ? wdata[3:0] : 4'b0000;
    key_edge_d = (key_edge_q & ~edge_clr) | edge_set;
    irq_en_d   = (reg_wr && addr == ADDR_IRQ_EN) ? wdata[3:0] : irq_en_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q    <= SYNC_IDLE;
      sync2_q    <= SYNC_IDLE;
      stable_q   <= '0;
      key_edge_q <= 4'b0000;
      irq_en_q   <= 4'b0000;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      key_edge_q <= key_edge_d;
      irq_en_q   <= irq_en_d;
      for (int i = 0; i < N_IN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (cs) begin
      case (addr)
        ADDR_SW_STATE:  rdata[9:0] = stable_q[9:0];
        ADDR_KEY_STATE: rdata[3:0] = stable_q[13:10];
        ADDR_KEY_EDGE:  rdata[3:0] = key_edge_q;
        ADDR_IRQ_EN:    rdata[3:0] = irq_en_q;
        default:        rdata      = '0;
      endcase
    end
  end

  assign irq = |(key_edge_q & irq_en_q);

endmodule

// File: tb/tb_io_input_port.sv
// tb/tb_io_input_port.sv - directed bench for io_input_port with a sample-window reference model
module tb_io_input_port;

  localparam int DC = 4;

  logic        clock;
  logic        resetn;
  logic [9:0]  SW;
  logic [3:0]  KEY;
  logic        cs;
  logic [1:0]  addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  io_input_port #(.DEBOUNCE_CYCLES(DC)) dut (
    .clock (clock),
    .resetn(resetn),
    .SW    (SW),
    .KEY   (KEY),
    .cs    (cs),
    .addr  (addr),
    .wen   (wen),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: pins reach the debouncer two edges late; a bit flips once the last DC samples all disagree with it.
  logic [13:0] m_d1, m_d2, m_stable, m_nxt, m_s;
  logic [3:0]  m_edge, m_irqen, m_set, m_clr;
  logic        m_valid = 1'b0;
  logic        m_all;
  logic [13:0] m_win[$];

  always @(posedge clock) begin
    if (!resetn) begin
      m_d1     = {4'hF, 10'h000};
      m_d2     = {4'hF, 10'h000};
      m_win.delete();
      m_stable = '0;
      m_edge   = '0;
      m_irqen  = '0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      m_s = {~m_d2[13:10], m_d2[9:0]};
      m_win.push_back(m_s);
      if (m_win.size() > DC) void'(m_win.pop_front());
      m_nxt = m_stable;
      if (m_win.size() == DC) begin
        for (int b = 0; b < 14; b++) begin
          m_all = 1'b1;
          foreach (m_win[k]) if (m_win[k][b] == m_stable[b]) m_all = 1'b0;
          if (m_all) m_nxt[b] = ~m_stable[b];
        end
      end
      m_set  = m_nxt[13:10] & ~m_stable[13:10];
      m_clr  = (cs && wen && addr == 2'd2) ? wdata[3:0] : 4'b0000;
      m_edge = (m_edge & ~m_clr) | m_set;
      if (cs && wen && addr == 2'd3) m_irqen = wdata[3:0];
      m_stable = m_nxt;
      m_d2 = m_d1;
      m_d1 = {KEY, SW};
    end
  end

  function automatic logic [31:0] model_rdata();
    logic [31:0] r;
    r = '0;
    if (cs) begin
      case (addr)
        2'd0:    r[9:0] = m_stable[9:0];
        2'd1:    r[3:0] = m_stable[13:10];
        2'd2:    r[3:0] = m_edge;
        default: r[3:0] = m_irqen;
      endcase
    end
    return r;
  endfunction

  always @(negedge clock) begin
    if (m_valid) begin
      checks++;
      if (rdata !== model_rdata()) begin
        errors++;
        $display("FAIL model_rdata t=%0t cs=%0b addr=%0d got %h expected %h", $time, cs, addr, rdata, model_rdata());
      end
      checks++;
      if (irq !== |(m_edge & m_irqen)) begin
        errors++;
        $display("FAIL model_irq t=%0t got %0b expected %0b", $time, irq, |(m_edge & m_irqen));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    cs   = 1'b1;
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic wr(input logic c, input logic [1:0] a, input logic [31:0] d);
    cs    = c;
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
    cs    = 1'b1;
  endtask

  logic [31:0] v;

  initial begin
    SW = '0; KEY = 4'hF; cs = 1'b0; addr = '0; wen = 1'b0; wdata = '0; resetn = 1'b0;
    repeat (3) tick();

    // Switch acquisition after reset
    SW = 10'h2A5; resetn = 1'b1; cs = 1'b1; addr = 2'd0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      peek(2'd0, v);
      lit("sw_state", v, (e < 6) ? 32'h0 : 32'h2A5);
      peek(2'd2, v);
      lit("key_edge_idle", v, 32'h0);
      lit("irq_idle", 32'(irq), 32'h0);
    end

    // Short glitches on KEY[1] are filtered, then a steady press lands
    for (int g = 0; g < 4; g++) begin
      KEY = 4'b1101;
      repeat (3) begin tick(); peek(2'd1, v); lit("key_state_glitch", v, 32'h0); end
      KEY = 4'b1111;
      tick(); peek(2'd1, v); lit("key_state_glitch", v, 32'h0);
    end
    KEY = 4'b1101;
    for (int e = 1; e <= 6; e++) begin
      tick();
      peek(2'd1, v);
      lit("key_state_hold", v, (e < 6) ? 32'h0 : 32'h2);
      peek(2'd2, v);
      lit("key_edge_hold", v, (e < 6) ? 32'h0 : 32'h2);
    end

    // Interrupt gating and W1C
    KEY = 4'b1001;
    repeat (6) tick();
    peek(2'd2, v); lit("key_edge_0110", v, 32'h6);
    lit("irq_masked", 32'(irq), 32'h0);
    wr(1'b1, 2'd3, 32'h4);
    lit("irq_enabled", 32'(irq), 32'h1);
    peek(2'd3, v); lit("irq_en_rb", v, 32'h4);
    wr(1'b1, 2'd2, 32'h4);
    lit("irq_cleared", 32'(irq), 32'h0);
    peek(2'd2, v); lit("key_edge_w1c", v, 32'h2);
    cs = 1'b0; #1; lit("rdata_cs0", rdata, 32'h0);
    wr(1'b0, 2'd2, 32'hF);
    peek(2'd2, v); lit("key_edge_cs0_wr", v, 32'h2);
    wr(1'b0, 2'd3, 32'h0);
    peek(2'd3, v); lit("irq_en_cs0_wr", v, 32'h4);
    wr(1'b1, 2'd0, 32'hFFFF_FFFF);
    peek(2'd0, v); lit("sw_state_ro", v, 32'h2A5);

    // KEY[3] edge coincides with a W1C of bit 3
    KEY = 4'b0001;
    repeat (5) tick();
    peek(2'd2, v); lit("key_edge_pre3", v, 32'h2);
    wr(1'b1, 2'd2, 32'h8);
    peek(2'd2, v); lit("key_edge_set_wins", v, 32'hA);
    peek(2'd1, v); lit("key_state_1110", v, 32'hE);

    // Reset mid-debounce with KEY[0] held
    KEY = 4'b0000;
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      peek(2'd2, v);
      lit("key_edge0_after_rst", 32'(v[0]), (e == 6) ? 32'h1 : 32'h0);
      if (e == 6) begin
        peek(2'd0, v); lit("sw_reacquired", v, 32'h2A5);
        peek(2'd1, v); lit("keys_reacquired", v, 32'hF);
      end
    end
    lit("irq_after_rst", 32'(irq), 32'h0);
    wr(1'b1, 2'd3, 32'h1);
    lit("irq_key0", 32'(irq), 32'h1);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Memory-mapped input peripheral for the single-cycle MIPS computer; the reading counterpart of the LED/7-segment output ports.
- Samples raw board switches SW[9:0] and push-buttons KEY[3:0], synchronises and debounces them, and latches button-press events.
- The CPU reads state and events through a four-word register window and can raise an interrupt on masked press events.
- Sits inside sc_computer on the data-memory I/O decode, clocked by the PLL output clock.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronised input must differ from its debounced value before the debounced value updates; minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of each per-bit debounce counter.

Ports:
- clock  input  1  system clock (PLL output)
- resetn  input  1  synchronous reset, active-low
- SW  input  10  raw slide switches, asynchronous
- KEY  input  4  raw push-buttons, asynchronous, active-low (0 = pressed)
- cs  input  1  chip select from the CPU address decode
- addr  input  2  word offset within the window (CPU address bits [3:2])
- wen  input  1  write strobe, qualified by cs
- wdata  input  32  write data
- rdata  output  32  read data, combinational
- irq  output  1  interrupt request, level, active-high

Behaviour:
- Reset (resetn low at a clock edge): all synchroniser flops go to their idle values (SW 0, KEY 1). Debounced SW and pressed-KEY values go to 0. Counters, KEY_EDGE and IRQ_EN go to 0. irq = 0 immediately after the reset edge.
- Synchroniser: each raw bit passes through two flops; sync2 is the second-stage output. KEY is inverted after synchronisation, so pressed = 1.
- Per-bit debounce (14 independent instances):
  - If sync2 equals the stable value, the counter clears.
  - Otherwise the counter increments. When the counter equals DEBOUNCE_CYCLES-1 and a mismatch is still present, stable takes sync2 at that edge and the counter clears.
  - Any bounce back to the stable value restarts the count.
  - Latency from a clean pin change to the stable change is 2 + DEBOUNCE_CYCLES clock edges.
  - A pulse shorter than DEBOUNCE_CYCLES cycles at sync2 is never seen.
- Edge capture: KEY_EDGE[i] sets on the cycle its stable pressed bit goes 0->1, and stays sticky until cleared. Releases are not captured.
- Register map (addr):
  - 0: SW_STATE, rdata[9:0] = debounced SW, read-only.
  - 1: KEY_STATE, rdata[3:0] = debounced pressed keys, read-only.
  - 2: KEY_EDGE, rdata[3:0]. Write-1-to-clear: when cs & wen, each bit with wdata[i]=1 clears.
  - 3: IRQ_EN, rdata[3:0], read/write: when cs & wen, IRQ_EN <= wdata[3:0].
- Unused rdata bits are 0. rdata = 0 whenever cs = 0.
- Writes to addr 0/1 are ignored. Writes with cs = 0 are ignored.
- Simultaneous set and W1C clear of the same KEY_EDGE bit in one cycle: set wins, and the bit stays 1.
- irq = |(KEY_EDGE & IRQ_EN), combinational from flops. It rises the cycle after the edge bit sets, or the cycle after IRQ_EN is written with a pending edge.
- Reset mid-debounce discards the count. After reset a held switch is re-acquired in 2 + DEBOUNCE_CYCLES cycles with no edge event. A key held through reset produces a KEY_EDGE event once debounced, because the post-reset stable value is 0 (not pressed).

Test Plan (DEBOUNCE_CYCLES=4):
- Reset hold, then SW=10'h2A5 steady → SW_STATE reads 0 for the first 5 edges and 10'h2A5 from edge 6. KEY_EDGE = 0, irq = 0.
- KEY[1] driven low with 3-cycle glitches (low 3, high 1) repeated, then held low → KEY_STATE stays 0 during the glitches. After the steady hold, KEY_STATE=4'b0010 and KEY_EDGE=4'b0010 after 6 edges.
- KEY_EDGE=4'b0110 pending, write addr 2 wdata=4'b0100 → KEY_EDGE reads 4'b0010. A write with cs=0 leaves it unchanged.
- IRQ_EN=0 with KEY_EDGE[2]=1 → irq=0. Write IRQ_EN=4'b0100 → irq=1 next cycle. Clear KEY_EDGE[2] → irq=0 next cycle.
- KEY[3] stable-press edge in the same cycle as a W1C of bit 3 → KEY_EDGE[3] reads 1 afterwards.
- KEY[0] held low, resetn pulsed mid-count → counters restart. KEY_EDGE[0] sets exactly 6 edges after resetn returns high.
